// File: rtl/ddr2_mem_tester_if.sv
// rtl/ddr2_mem_tester_if.sv - local (Avalon-style) request/response port between tester and DDR2 controller
interface ddr2_mem_tester_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 128
);
  logic              local_init_done;
  logic              local_ready;
  logic [DATA_W-1:0] local_rdata;
  logic              local_rdata_valid;
  logic [ADDR_W-1:0] local_address;
  logic              local_write_req;
  logic              local_read_req;
  logic              local_burstbegin;
  logic [DATA_W-1:0] local_wdata;

  modport master (
    input  local_init_done, local_ready, local_rdata, local_rdata_valid,
    output local_address, local_write_req, local_read_req, local_burstbegin, local_wdata
  );

  modport slave (
    output local_init_done, local_ready, local_rdata, local_rdata_valid,
    input  local_address, local_write_req, local_read_req, local_burstbegin, local_wdata
  );
endinterface

// File: rtl/ddr2_mem_tester.sv
// rtl/ddr2_mem_tester.sv - DDR2 local-port traffic generator with in-order read-back checker
// Writes an address/seed pattern over a window, reads it back, counts mismatches, repeats per pass.
module ddr2_mem_tester #(
  parameter int ADDR_W     = 26,
  parameter int DATA_W     = 128,
  parameter int BASE_ADDR  = 0,
  parameter int NUM_WORDS  = 1024,
  parameter int MAX_OUTST  = 8,
  parameter int TIMEOUT    = 4096,
  parameter int NUM_PASSES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  ddr2_mem_tester_if.master bus,
  output logic              led_o,
  output logic              err_flag_o,
  output logic [15:0]       err_count_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [15:0]       pass_count_o
);
  localparam int LANES = DATA_W / 32;
  localparam int OW    = $clog2(MAX_OUTST + 1);
  localparam int WW    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(NUM_WORDS - 1);
  localparam logic [OW-1:0]     OUT_MAX = OW'(MAX_OUTST);
  localparam logic [WW-1:0]     WD_MAX  = WW'(TIMEOUT);
  localparam logic [15:0]       PASSES  = 16'(NUM_PASSES);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_DRAIN, S_NEXT, S_DONE, S_FAIL
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d, j_q, j_d, addr_q, addr_d, eaddr_q, eaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d, rd_q, rd_d, bb_q, bb_d;
  logic              led_q, led_d, errf_q, errf_d;
  logic [15:0]       errc_q, errc_d, pass_q, pass_d;
  logic [7:0]        p_q, p_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic              acc_w, acc_r, held, rvalid, spurious, timeout, mismatch;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] addr, input logic [7:0] seed);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++)
      r[k*32 +: 32] = 32'(addr) ^ {4{seed}} ^ (32'(k) * 32'h9E3779B9);
    return r;
  endfunction

  assign acc_w    = wr_q & bus.local_ready;
  assign acc_r    = rd_q & bus.local_ready;
  assign held     = (wr_q | rd_q) & ~bus.local_ready;
  assign rvalid   = bus.local_rdata_valid;
  assign spurious = rvalid & (outst_q == '0);

  // A spurious response never decrements the count; accept and return together cancel.
  always_comb begin
    outst_d = outst_q;
    if (acc_r && !(rvalid && !spurious))
      outst_d = outst_q + 1'b1;
    else if (!acc_r && rvalid && !spurious)
      outst_d = outst_q - 1'b1;
  end

  assign wd_d    = (rvalid || outst_q == '0 || state_q == S_FAIL) ? '0 : wd_q + 1'b1;
  assign timeout = (wd_d == WD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    case (state_q)
      S_IDLE: begin
        if (bus.local_init_done) state_d = S_WRITE;
        i_d = '0;
      end
      S_WRITE: if (acc_w) begin
        if (i_q == LAST) begin
          state_d = S_READ;
          i_d     = '0;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_READ: if (acc_r) begin
        if (i_q == LAST) state_d = S_DRAIN;
        else             i_d     = i_q + 1'b1;
      end
      S_DRAIN: if (outst_q == '0) state_d = S_NEXT;
      S_NEXT: begin
        i_d     = '0;
        state_d = (PASSES != 16'd0 && pass_q + 16'd1 == PASSES) ? S_DONE : S_WRITE;
      end
      default: ;
    endcase
    if (timeout) state_d = S_FAIL;
  end

  // Request outputs are registered: next values come from the upcoming state and index.
  always_comb begin
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    bb_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    p_d     = p_q;
    pass_d  = pass_q;
    if (state_q == S_NEXT) begin
      p_d    = p_q + 8'd1;
      pass_d = pass_q + 16'd1;
    end
    if (state_d == S_WRITE) begin
      wr_d = 1'b1;
      if (!held) begin
        bb_d    = 1'b1;
        addr_d  = BASE + i_d;
        wdata_d = pattern(BASE + i_d, p_d);
      end
    end else if (state_d == S_READ) begin
      if (held) begin
        rd_d = 1'b1;
      end else if (outst_d < OUT_MAX) begin
        rd_d   = 1'b1;
        bb_d   = 1'b1;
        addr_d = BASE + i_d;
      end
    end

    j_d      = j_q;
    errc_d   = errc_q;
    errf_d   = errf_q;
    eaddr_d  = eaddr_q;
    mismatch = 1'b0;
    if (state_q == S_WRITE && state_d == S_READ) j_d = '0;
    if (rvalid) begin
      if (spurious) begin
        mismatch = 1'b1;
      end else begin
        mismatch = (bus.local_rdata != pattern(BASE + j_q, p_q));
        j_d      = j_q + 1'b1;
      end
    end
    if (mismatch) begin
      if (errc_q != 16'hFFFF) errc_d = errc_q + 16'd1;
      errf_d = 1'b1;
      if (!errf_q) eaddr_d = BASE + j_q;
    end
    if (timeout) errf_d = 1'b1;

    led_d = led_q;
    if (state_q == S_NEXT && !errf_q) led_d = ~led_q;
    if (errf_d) led_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0; j_q <= '0; addr_q <= '0; eaddr_q <= '0; wdata_q <= '0;
      wr_q <= 1'b0; rd_q <= 1'b0; bb_q <= 1'b0; led_q <= 1'b0; errf_q <= 1'b0;
      errc_q <= '0; pass_q <= '0; p_q <= '0; outst_q <= '0; wd_q <= '0;
    end else begin
      i_q <= i_d; j_q <= j_d; addr_q <= addr_d; eaddr_q <= eaddr_d; wdata_q <= wdata_d;
      wr_q <= wr_d; rd_q <= rd_d; bb_q <= bb_d; led_q <= led_d; errf_q <= errf_d;
      errc_q <= errc_d; pass_q <= pass_d; p_q <= p_d; outst_q <= outst_d; wd_q <= wd_d;
    end
  end

  assign bus.local_address    = addr_q;
  assign bus.local_write_req  = wr_q;
  assign bus.local_read_req   = rd_q;
  assign bus.local_burstbegin = bb_q;
  assign bus.local_wdata      = wdata_q;
  assign led_o                = led_q;
  assign err_flag_o           = errf_q;
  assign err_count_o          = errc_q;
  assign err_addr_o           = eaddr_q;
  assign pass_count_o         = pass_q;
endmodule

// File: tb/tb_ddr2_mem_tester.sv
// tb/tb_ddr2_mem_tester.sv - scenario table plus behavioural controller/memory model for ddr2_mem_tester
`timescale 1ns/1ps
module tb_ddr2_mem_tester;
  localparam int AW = 26, DW = 128, BASE = 256, NW = 16, MO = 4, TO = 64, NP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr2_mem_tester_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  logic          led, err_flag;
  logic [15:0]   err_count, pass_count;
  logic [AW-1:0] err_addr;

  ddr2_mem_tester #(
    .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE), .NUM_WORDS(NW),
    .MAX_OUTST(MO), .TIMEOUT(TO), .NUM_PASSES(NP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .led_o(led), .err_flag_o(err_flag), .err_count_o(err_count),
    .err_addr_o(err_addr), .pass_count_o(pass_count)
  );

  typedef struct {
    int rmode;    // 0 always ready, 1 ready every 4th cycle, 2 random
    int lat;      // read latency, -1 = random 1..12
    int flip_idx; // read index whose bit 0 is corrupted, -1 none
    int drop_idx; // read index whose response is lost, -1 none
    int exp_pass, exp_errc, exp_errf, exp_eaddr, exp_led1, exp_writes, exp_reads, exp_fail, exp_max;
  } sc_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  sc_t tbl [6];
  int tests = 0, failed = 0;
  int cfg_rmode = 0, cfg_lat = 5, cfg_flip = -1, cfg_drop = -1;

  int cyc = 0, writes, reads, rsps, outst_m, max_seen, same_cnt, viol, last_rsp_cyc, last_due;
  logic          prev_held, prev_wr, prev_rd;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  logic [DW-1:0] mem [NW];
  rsp_t          rdq [$];

  function automatic logic [DW-1:0] pat(input int addr, input int p);
    logic [DW-1:0] r;
    logic [31:0]   a, s;
    a = 32'(addr);
    s = {4{p[7:0]}};
    for (int k = 0; k < DW / 32; k++) r[32*k +: 32] = a ^ s ^ (32'(k) * 32'h9E3779B9);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller model: decides ready for the next edge, records accepts, returns reads in order.
  always @(negedge clk) begin : model
    logic wr, rd, rdy, acc_r;
    int   idx, due;
    rsp_t r;
    cyc++;
    if (!rst_n) begin
      bus.local_ready = 1'b0; bus.local_rdata_valid = 1'b0; bus.local_rdata = '0;
      rdq.delete();
      writes = 0; reads = 0; rsps = 0; outst_m = 0; max_seen = 0; same_cnt = 0; viol = 0;
      last_rsp_cyc = 0; last_due = 0; prev_held = 1'b0; prev_wr = 1'b0; prev_rd = 1'b0;
      prev_addr = '0; prev_wdata = '0;
    end else begin
      wr = bus.local_write_req;
      rd = bus.local_read_req;
      if (wr && rd) viol++;
      if (bus.local_burstbegin !== ((wr || rd) && !prev_held)) viol++;
      if (prev_held && (wr !== prev_wr || rd !== prev_rd || bus.local_address !== prev_addr ||
                        (prev_wr && bus.local_wdata !== prev_wdata))) viol++;
      case (cfg_rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.local_ready = rdy;
      acc_r = rd && rdy;
      if (wr && rdy) begin
        idx = writes % NW;
        if (bus.local_address !== AW'(BASE + idx)) viol++;
        if (bus.local_wdata !== pat(BASE + idx, writes / NW)) viol++;
        mem[idx] = bus.local_wdata;
        writes++;
      end
      if (acc_r) begin
        idx = reads % NW;
        if (bus.local_address !== AW'(BASE + idx)) viol++;
        due = cyc + ((cfg_lat < 0) ? int'($urandom_range(1, 12)) : cfg_lat);
        if (due <= last_due) due = last_due + 1;
        r.due  = due;
        r.data = mem[idx];
        if (reads == cfg_flip) r.data[0] = ~r.data[0];
        if (reads != cfg_drop) begin
          rdq.push_back(r);
          last_due = due;
        end
        reads++;
        outst_m++;
      end
      if (rdq.size() > 0 && rdq[0].due <= cyc) begin
        bus.local_rdata       = rdq[0].data;
        bus.local_rdata_valid = 1'b1;
        rdq.pop_front();
        outst_m--;
        rsps++;
        last_rsp_cyc = cyc;
        if (acc_r) same_cnt++;
      end else begin
        bus.local_rdata_valid = 1'b0;
      end
      if (outst_m > max_seen) max_seen = outst_m;
      prev_held  = (wr || rd) && !rdy;
      prev_wr    = wr;
      prev_rd    = rd;
      prev_addr  = bus.local_address;
      prev_wdata = bus.local_wdata;
    end
  end

  task automatic run_sc(input int id, input sc_t s);
    int led_p1, fail_cyc, late, d;
    bit fail_seen;
    rst_n = 1'b0;
    bus.local_init_done = 1'b0;
    cfg_rmode = s.rmode; cfg_lat = s.lat; cfg_flip = s.flip_idx; cfg_drop = s.drop_idx;
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("s%0d_rst_req", id), 64'({bus.local_write_req, bus.local_read_req, bus.local_burstbegin}), 64'd0);
    check($sformatf("s%0d_rst_bus_zero", id), 64'(bus.local_address == '0 && bus.local_wdata == '0), 64'd1);
    check($sformatf("s%0d_rst_status_zero", id),
          64'({led, err_flag, err_count, err_addr, pass_count} == '0), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.local_init_done = 1'b1;
    led_p1 = 2; fail_seen = 1'b0; fail_cyc = 0; late = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      if (pass_count == 16'd1 && led_p1 == 2) led_p1 = int'(led);
      if (err_flag && !fail_seen) begin
        fail_seen = 1'b1;
        fail_cyc  = cyc;
      end
      if (c >= 1480 && (bus.local_write_req || bus.local_read_req)) late++;
    end
    check($sformatf("s%0d_pass_count", id), 64'(pass_count), 64'(s.exp_pass));
    check($sformatf("s%0d_err_count", id), 64'(err_count), 64'(s.exp_errc));
    check($sformatf("s%0d_err_flag", id), 64'(err_flag), 64'(s.exp_errf));
    check($sformatf("s%0d_err_addr", id), 64'(err_addr), 64'(s.exp_eaddr));
    check($sformatf("s%0d_led_after_pass1", id), 64'(led_p1), 64'(s.exp_led1));
    check($sformatf("s%0d_led_final", id), 64'(led), 64'd0);
    check($sformatf("s%0d_writes", id), 64'(writes), 64'(s.exp_writes));
    check($sformatf("s%0d_reads", id), 64'(reads), 64'(s.exp_reads));
    check($sformatf("s%0d_protocol_violations", id), 64'(viol), 64'd0);
    check($sformatf("s%0d_idle_at_end", id), 64'(late), 64'd0);
    check($sformatf("s%0d_outst_bound", id), 64'(max_seen <= MO), 64'd1);
    if (s.exp_max != 0) begin
      check($sformatf("s%0d_outst_peak", id), 64'(max_seen), 64'(s.exp_max));
      check($sformatf("s%0d_accept_with_return", id), 64'(same_cnt > 0), 64'd1);
    end
    if (s.exp_fail != 0) begin
      d = fail_cyc - last_rsp_cyc;
      check($sformatf("s%0d_timeout_cycles", id), 64'(d >= TO - 1 && d <= TO + 2), 64'd1);
    end
  endtask

  task automatic reset_mid_read();
    bit found;
    int reqs;
    rst_n = 1'b0;
    bus.local_init_done = 1'b0;
    cfg_rmode = 0; cfg_lat = 40; cfg_flip = -1; cfg_drop = -1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.local_init_done = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(posedge clk);
      #1;
      if (reads > 0 && outst_m == 3) found = 1'b1;
    end
    check("rst6_reached_3_outstanding", 64'(found), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst6_req_dropped", 64'({bus.local_write_req, bus.local_read_req, bus.local_burstbegin}), 64'd0);
    check("rst6_addr_zero", 64'(bus.local_address), 64'd0);
    bus.local_init_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    reqs = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.local_write_req || bus.local_read_req) reqs++;
    end
    check("rst6_waits_init_done", 64'(reqs), 64'd0);
    bus.local_init_done = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk);
      #1;
      if (bus.local_write_req || bus.local_read_req) found = 1'b1;
    end
    check("rst6_restart_seen", 64'(found), 64'd1);
    check("rst6_restart_is_write", 64'({bus.local_write_req, bus.local_read_req}), 64'b10);
    check("rst6_restart_addr", 64'(bus.local_address), 64'(BASE));
  endtask

  initial begin
    tbl[0] = '{0,  5, -1, -1, 2, 0, 0, 0,        1, 32, 32, 0, 0};
    tbl[1] = '{1,  5, -1, -1, 2, 0, 0, 0,        1, 32, 32, 0, 0};
    tbl[2] = '{0,  5,  5, -1, 2, 1, 1, BASE + 5, 0, 32, 32, 0, 0};
    tbl[3] = '{0, 40, -1, -1, 2, 0, 0, 0,        1, 32, 32, 0, MO};
    tbl[4] = '{0,  5, -1, NW - 1, 0, 0, 1, 0,    2, 16, 16, 1, 0};
    tbl[5] = '{2, -1, -1, -1, 2, 0, 0, 0,        1, 32, 32, 0, 0};
    bus.local_init_done = 1'b0;
    for (int i = 0; i < 6; i++) run_sc(i, tbl[i]);
    reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
